// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared types and default marker values for stream_program_loader.
//   loader_state_e     : loader FSM states (CHECK is only reachable when the
//                        checksum feature is built in).
//   entry_mark_default : all-ones word of the given width.
//   end_mark_default   : all-ones-minus-one word of the given width.
//   Both functions return MARK_MAX_W bits; callers size-cast to their width.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

    localparam int MARK_MAX_W = 256;

    function automatic logic [MARK_MAX_W-1:0] entry_mark_default(input int word_w);
        return {MARK_MAX_W{1'b1}} >> (MARK_MAX_W - word_w);
    endfunction

    function automatic logic [MARK_MAX_W-1:0] end_mark_default(input int word_w);
        return entry_mark_default(word_w) - {{(MARK_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler
//   Packs a stream of bytes into words of BYTES_PER_WORD bytes.
//   The completed word is presented combinationally in the same cycle as the
//   final byte, so the consumer can register it with a single cycle of latency.
// Parameters
//   BYTES_PER_WORD : bytes per word (WORD_W = 8*BYTES_PER_WORD)
//   MSB_FIRST      : 1 = first byte lands in the top byte, 0 = in bits [7:0]
// Ports
//   CLK        in  clock
//   clear      in  synchronous clear of byte counter and partial word
//   data_byte  in  incoming byte
//   valid      in  accept data_byte this cycle
//   word       out assembled word (meaningful while word_valid=1)
//   word_valid out 1 in the cycle the final byte of a word is accepted
module word_assembler #(
    parameter int BYTES_PER_WORD = 4,
    parameter bit MSB_FIRST      = 1'b1,
    localparam int WORD_W        = 8 * BYTES_PER_WORD
) (
    input  logic              CLK,
    input  logic              clear,
    input  logic [7:0]        data_byte,
    input  logic              valid,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    generate
        if (BYTES_PER_WORD == 1) begin : g_single
            assign word       = data_byte;
            assign word_valid = valid;
        end else begin : g_multi
            localparam int CNT_W = $clog2(BYTES_PER_WORD);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

            logic [CNT_W-1:0]  cnt_reg;
            // Only the bytes received so far are stored; the incoming byte
            // completes the word combinationally.
            logic [WORD_W-9:0] part_reg;
            logic [WORD_W-1:0] merged;
            logic [WORD_W-9:0] part_next;

            if (MSB_FIRST) begin : g_msb
                assign merged    = {part_reg, data_byte};
                assign part_next = merged[WORD_W-9:0];
            end else begin : g_lsb
                assign merged    = {data_byte, part_reg};
                assign part_next = merged[WORD_W-1:8];
            end

            always_ff @(posedge CLK) begin
                if (clear) begin
                    cnt_reg  <= '0;
                    part_reg <= '0;
                end else if (valid) begin
                    cnt_reg  <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
                    part_reg <= part_next;
                end
            end

            assign word       = merged;
            assign word_valid = valid && (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/stream_program_loader.sv
// stream_program_loader
//   Boot-time loader: packs the receiver byte stream into words and writes
//   them to instruction memory through a single write port. The core may
//   release its PC once done=1.
// Optional feature (macro LOADER_CHECKSUM_EN): running XOR of all written
//   words, compared against one extra word following END_MARK.
// Ports
//   CLK          in  clock
//   RST          in  synchronous active-high reset; aborts a load in progress
//   needed       in  load enable (level); low during a load pauses it
//   rx_data      in  byte from receiver
//   rx_valid     in  1-cycle strobe qualifying rx_data
//   mem_we       out 1-cycle write strobe
//   mem_addr     out word index
//   mem_wdata    out assembled word
//   pc_init      out index after the last ENTRY_MARK word (0 if none)
//   entry_found  out at least one ENTRY_MARK written
//   done         out load finished, sticky until RST
//   overflow     out a word arrived with memory already full, sticky
//   chk_err      out checksum mismatch (0 without LOADER_CHECKSUM_EN)
module stream_program_loader
    import loader_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter bit MSB_FIRST      = 1'b1,
    parameter logic [8*BYTES_PER_WORD-1:0] ENTRY_MARK =
        (8*BYTES_PER_WORD)'(entry_mark_default(8*BYTES_PER_WORD)),
    parameter logic [8*BYTES_PER_WORD-1:0] END_MARK =
        (8*BYTES_PER_WORD)'(end_mark_default(8*BYTES_PER_WORD))
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        needed,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [8*BYTES_PER_WORD-1:0] mem_wdata,
    output logic [ADDR_W:0]             pc_init,
    output logic                        entry_found,
    output logic                        done,
    output logic                        overflow,
    output logic                        chk_err
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam logic [ADDR_W:0] IDX_FULL = (ADDR_W+1)'(DEPTH);

    loader_state_e     state_reg, state_next;
    // One bit wider than the address so "memory full" is representable.
    logic [ADDR_W:0]   idx_reg, idx_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [WORD_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [ADDR_W:0]   pc_init_reg, pc_init_next;
    logic              entry_found_reg, entry_found_next;
    logic              done_reg, done_next;
    logic              overflow_reg, overflow_next;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] xor_reg, xor_next;
    logic              chk_err_reg, chk_err_next;
`endif

    logic              accept;
    logic [WORD_W-1:0] word;
    logic              word_valid;

    // CHECK also consumes bytes: it assembles the trailing checksum word.
    assign accept = rx_valid && needed && (state_reg == LOAD || state_reg == CHECK);

    word_assembler #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .MSB_FIRST      (MSB_FIRST)
    ) u_asm (
        .CLK        (CLK),
        .clear      (RST),
        .data_byte  (rx_data),
        .valid      (accept),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            pc_init_reg     <= '0;
            entry_found_reg <= 1'b0;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_reg         <= '0;
            chk_err_reg     <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            pc_init_reg     <= pc_init_next;
            entry_found_reg <= entry_found_next;
            done_reg        <= done_next;
            overflow_reg    <= overflow_next;
`ifdef LOADER_CHECKSUM_EN
            xor_reg         <= xor_next;
            chk_err_reg     <= chk_err_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        mem_we_next      = 1'b0;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        pc_init_next     = pc_init_reg;
        entry_found_next = entry_found_reg;
        done_next        = done_reg;
        overflow_next    = overflow_reg;
`ifdef LOADER_CHECKSUM_EN
        xor_next         = xor_reg;
        chk_err_next     = chk_err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (needed) state_next = LOAD;
            end
            LOAD: begin
                if (word_valid) begin
                    // END_MARK is tested before the full check so that an end
                    // word arriving with memory full is a clean finish.
                    if (word == END_MARK) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
                        done_next  = 1'b1;
`endif
                    end else if (idx_reg == IDX_FULL) begin
                        overflow_next = 1'b1;
                        state_next    = DONE;
                        done_next     = 1'b1;
                    end else begin
                        mem_we_next    = 1'b1;
                        mem_addr_next  = idx_reg[ADDR_W-1:0];
                        mem_wdata_next = word;
                        idx_next       = idx_reg + 1'b1;
                        if (word == ENTRY_MARK) begin
                            pc_init_next     = idx_reg + 1'b1;
                            entry_found_next = 1'b1;
                        end
`ifdef LOADER_CHECKSUM_EN
                        xor_next = xor_reg ^ word;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (word_valid) begin
                    chk_err_next = (word != xor_reg);
                    done_next    = 1'b1;
                    state_next   = DONE;
                end
            end
`endif
            default: ;
        endcase
    end

    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign pc_init     = pc_init_reg;
    assign entry_found = entry_found_reg;
    assign done        = done_reg;
    assign overflow    = overflow_reg;
`ifdef LOADER_CHECKSUM_EN
    assign chk_err     = chk_err_reg;
`else
    assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_stream_program_loader.sv
// tb_stream_program_loader
//   Three loader instances share one stimulus: default parameters (d0),
//   MSB_FIRST=0 (d1) and DEPTH=4 (d2). Each vector names the instance whose
//   outputs are compared after the clock edge that consumes it.
module tb_stream_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       needed = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    always #5 CLK = ~CLK;

    logic        we0, ef0, dn0, ov0, ce0;
    logic [9:0]  addr0;
    logic [31:0] wd0;
    logic [10:0] pc0;
    logic        we1, ef1, dn1, ov1, ce1;
    logic [9:0]  addr1;
    logic [31:0] wd1;
    logic [10:0] pc1;
    logic        we2, ef2, dn2, ov2, ce2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  pc2;

    stream_program_loader d0 (
        .CLK(CLK), .RST(RST), .needed(needed), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0), .pc_init(pc0),
        .entry_found(ef0), .done(dn0), .overflow(ov0), .chk_err(ce0));

    stream_program_loader #(.MSB_FIRST(1'b0)) d1 (
        .CLK(CLK), .RST(RST), .needed(needed), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .pc_init(pc1),
        .entry_found(ef1), .done(dn1), .overflow(ov1), .chk_err(ce1));

    stream_program_loader #(.DEPTH(4)) d2 (
        .CLK(CLK), .RST(RST), .needed(needed), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .pc_init(pc2),
        .entry_found(ef2), .done(dn2), .overflow(ov2), .chk_err(ce2));

    typedef struct {
        string       nm;
        int          dut;
        bit          rst;
        bit          need;
        bit          vld;
        logic [7:0]  b;
        bit          we;
        int          addr;
        logic [31:0] wd;
        bit          dn;
        bit          ov;
    } vec_t;

    vec_t tbl[$];
    vec_t c1[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int dut, input bit rst, input bit need,
                                input bit vld, input logic [7:0] b, input bit we, input int addr,
                                input logic [31:0] wd, input bit dn, input bit ov);
        vec_t v;
        v.nm = nm; v.dut = dut; v.rst = rst; v.need = need; v.vld = vld; v.b = b;
        v.we = we; v.addr = addr; v.wd = wd; v.dn = dn; v.ov = ov;
        return v;
    endfunction

    // Expands one word into four byte vectors; only the last byte can write
    // or change the sticky flags.
    task automatic add_word(input bit to_c1, input string nm, input int dut, input logic [31:0] w,
                            input bit msb, input bit we, input int addr,
                            input bit pre_dn, input bit pre_ov, input bit post_dn, input bit post_ov);
        vec_t v;
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = msb ? w[31-8*k -: 8] : w[8*k +: 8];
            v = mk($sformatf("%s.b%0d", nm, k), dut, 1'b0, 1'b1, 1'b1, b,
                   (k == 3) && we, addr, w, (k == 3) ? post_dn : pre_dn, (k == 3) ? post_ov : pre_ov);
            if (to_c1) c1.push_back(v);
            else       tbl.push_back(v);
        end
    endtask

    task automatic apply(input vec_t v);
        logic        we, dn, ov;
        int          a;
        logic [31:0] d;
        RST = v.rst; needed = v.need; rx_valid = v.vld; rx_data = v.b;
        @(posedge CLK); #1;
        RST = 1'b0; rx_valid = 1'b0;
        case (v.dut)
            0:       begin we = we0; a = 32'(addr0); d = wd0; dn = dn0; ov = ov0; end
            1:       begin we = we1; a = 32'(addr1); d = wd1; dn = dn1; ov = ov1; end
            default: begin we = we2; a = 32'(addr2); d = wd2; dn = dn2; ov = ov2; end
        endcase
        $display("vec %-10s d%0d byte=%02h need=%0d -> we=%0d addr=%0d wdata=%08h done=%0d ovf=%0d",
                 v.nm, v.dut, v.b, v.need, we, a, d, dn, ov);
        check({v.nm, " mem_we"}, 64'(we), 64'(v.we));
        if (v.we) begin
            check({v.nm, " mem_addr"}, 64'(a), 64'(v.addr));
            check({v.nm, " mem_wdata"}, 64'(d), 64'(v.wd));
        end
        check({v.nm, " done"}, 64'(dn), 64'(v.dn));
        check({v.nm, " overflow"}, 64'(ov), 64'(v.ov));
    endtask

    // Raw MSB-first word with needed=1, no per-byte comparison.
    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            needed = 1'b1; rx_valid = 1'b1; rx_data = w[31-8*k -: 8];
            @(posedge CLK); #1;
            rx_valid = 1'b0;
        end
        $display("sent word %08h", w);
    endtask

    task automatic run_case1(input string tag);
        apply(mk({tag, ".rst"}, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        foreach (c1[i]) apply(c1[i]);
        if (CK) send_word(32'hEDCB_A986); // XOR of the three written words
        $display("%s: pc_init=%0d entry_found=%0d done=%0d overflow=%0d chk_err=%0d",
                 tag, pc0, ef0, dn0, ov0, ce0);
        check({tag, " pc_init"}, 64'(pc0), 64'd2);
        check({tag, " entry_found"}, 64'(ef0), 64'd1);
        check({tag, " done"}, 64'(dn0), 64'd1);
        check({tag, " overflow"}, 64'(ov0), 64'd0);
        check({tag, " chk_err"}, 64'(ce0), 64'd0);
    endtask

    initial begin
        // ---- case 1 vectors: default params ----
        c1.push_back(mk("c1.arm", 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        add_word(1'b1, "c1.w0", 0, 32'h0000_0001, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_word(1'b1, "c1.w1", 0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_word(1'b1, "c1.w2", 0, 32'h1234_5678, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        add_word(1'b1, "c1.end", 0, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 1'b0, 1'b0, !CK, 1'b0);

        // ---- case 2: LSB-first ----
        tbl.push_back(mk("c2.rst", 1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c2.arm", 1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        add_word(1'b0, "c2.w0", 1, 32'h1234_5678, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- case 3: DEPTH=4 overflow ----
        tbl.push_back(mk("c3.rst", 2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c3.arm", 2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            add_word(1'b0, $sformatf("c3.w%0d", i), 2, 32'h10 + 32'(i), 1'b1, 1'b1, i,
                     1'b0, 1'b0, 1'b0, 1'b0);
        add_word(1'b0, "c3.w4", 2, 32'h14, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        add_word(1'b0, "c3.post", 2, 32'h15, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        // ---- case 4: needed dropped mid-word ----
        tbl.push_back(mk("c4.rst", 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.arm", 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.b0", 0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.b1", 0, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.low0", 0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.low1", 0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.low2", 0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.b2", 0, 1'b0, 1'b1, 1'b1, 8'hCC, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("c4.b3", 0, 1'b0, 1'b1, 1'b1, 8'hDD, 1'b1, 0, 32'hAABB_CCDD, 1'b0, 1'b0));

        // ---- end marker exactly at idx==DEPTH, entry marker in last slot ----
        tbl.push_back(mk("bd.rst", 2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk("bd.arm", 2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            add_word(1'b0, $sformatf("bd.w%0d", i), 2, 32'(i + 1), 1'b1, 1'b1, i,
                     1'b0, 1'b0, 1'b0, 1'b0);
        add_word(1'b0, "bd.mark", 2, 32'hFFFF_FFFF, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        add_word(1'b0, "bd.end", 2, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 1'b0, 1'b0, !CK, 1'b0);

        // ---- reset state ----
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst mem_we", 64'(we0), 64'd0);
        check("rst mem_addr", 64'(addr0), 64'd0);
        check("rst mem_wdata", 64'(wd0), 64'd0);
        check("rst pc_init", 64'(pc0), 64'd0);
        check("rst entry_found", 64'(ef0), 64'd0);
        check("rst done", 64'(dn0), 64'd0);
        check("rst overflow", 64'(ov0), 64'd0);
        check("rst chk_err", 64'(ce0), 64'd0);
        $display("reset: we=%0d addr=%0d wdata=%08h pc=%0d ef=%0d done=%0d ovf=%0d",
                 we0, addr0, wd0, pc0, ef0, dn0, ov0);
        RST = 1'b0;

        // ---- case 1 ----
        run_case1("c1");
        // Bytes after DONE must not write.
        for (int k = 0; k < 4; k++) begin
            needed = 1'b1; rx_valid = 1'b1; rx_data = 8'h09;
            @(posedge CLK); #1;
            rx_valid = 1'b0;
            check($sformatf("c1.after_done we%0d", k), 64'(we0), 64'd0);
        end

        // ---- table: cases 2, 3, 4 and DEPTH boundary ----
        foreach (tbl[i]) apply(tbl[i]);
        if (CK) send_word(32'hFFFF_FFFF); // 1^2^3^FFFF_FFFF
        $display("bd: pc_init=%0d entry_found=%0d done=%0d overflow=%0d", pc2, ef2, dn2, ov2);
        check("bd pc_init", 64'(pc2), 64'd4);
        check("bd entry_found", 64'(ef2), 64'd1);
        check("bd done", 64'(dn2), 64'd1);
        check("bd overflow", 64'(ov2), 64'd0);

        // ---- case 5: reset after 6 bytes, then clean case-1 stream ----
        apply(mk("c5.rst", 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        apply(mk("c5.arm", 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        for (int k = 0; k < 6; k++)
            apply(mk($sformatf("c5.pre%0d", k), 0, 1'b0, 1'b1, 1'b1, 8'(k + 1), k == 3, 0,
                     32'h0102_0304, 1'b0, 1'b0));
        run_case1("c5");

`ifdef LOADER_CHECKSUM_EN
        // ---- case 6: checksum ----
        apply(mk("c6.rst", 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        apply(mk("c6.arm", 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        send_word(32'h1); send_word(32'h2); send_word(32'hFFFF_FFFE);
        check("c6 done before check word", 64'(dn0), 64'd0);
        send_word(32'h3);
        check("c6 done", 64'(dn0), 64'd1);
        check("c6 chk_err good", 64'(ce0), 64'd0);
        apply(mk("c6b.rst", 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        apply(mk("c6b.arm", 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        send_word(32'h1); send_word(32'h2); send_word(32'hFFFF_FFFE); send_word(32'h4);
        check("c6b done", 64'(dn0), 64'd1);
        check("c6b chk_err bad", 64'(ce0), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
